ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

PS/2 host-to-device transmitter. It sends one command byte, such as 0xED (set LEDs), 0xFF (reset) or 0xF4 (enable), to the attached keyboard, using the host side of the same bidirectional clock/data pair that the existing PS/2 keyboard receiver listens on. It sits beside the receiver inside the apple1 core, on the clk25 domain. It drives the open-drain pins only through active-low-enable outputs, which the board top level turns into tri-states.

## Interface
Parameters:
- INHIBIT_CYCLES, 2500 — clock-inhibit hold time before the request (100 µs at 25 MHz).
- REQ_CYCLES, 25 — time data is held low together with clock before clock is released (1 µs).
- START_TIMEOUT, 375000 — maximum wait for the first device clock falling edge (15 ms).
- BIT_TIMEOUT, 50000 — maximum gap between consecutive device falling edges, and maximum wait for line idle after the ack (2 ms).

Ports (one clock; reset is synchronous and active-high):
- clk25  in  1  system clock, 25 MHz.
- rst  in  1  synchronous active-high reset.
- tx_data  in  8  command byte.
- tx_valid  in  1  request; accepted only when tx_ready=1.
- tx_ready  out  1  idle, can accept a byte.
- tx_busy  out  1  transfer in progress; the receiver must discard frames while this is high.
- tx_done  out  1  one-cycle pulse: the device acknowledged the byte.
- tx_error  out  1  one-cycle pulse: no ack, or a timeout occurred.
- ps2_clk_in  in  1  raw (asynchronous) PS/2 clock pin level.
- ps2_dat_in  in  1  raw PS/2 data pin level.
- ps2_clk_oe  out  1  1 = pull the clock line low.
- ps2_dat_oe  out  1  1 = pull the data line low.

## Operation
- Input conditioning: ps2_clk_in and ps2_dat_in each pass through a 2-FF synchronizer. A falling edge on the clock is a synchronized 1→0 transition.
- Frame sent: start 0, data D0..D7 (LSB first), odd parity (parity = ~^tx_data), stop 1. The device then acks by driving data low.
- Accept: in IDLE, when tx_valid=1 the block latches tx_data and parity into a 10-bit shift register {stop, parity, data} and moves to INHIBIT.
- States:
  - IDLE: both oe outputs 0; tx_ready=1.
  - INHIBIT: ps2_clk_oe=1 for INHIBIT_CYCLES, then go to REQ.
  - REQ: ps2_clk_oe=1 and ps2_dat_oe=1 (start bit) for REQ_CYCLES, then go to SEND and release the clock.
  - SEND:
    - ps2_clk_oe=0. ps2_dat_oe is held at 1 (start bit) until the first falling edge.
    - On each falling edge k=1..10, ps2_dat_oe <= ~shift[0] and the register shifts right.
    - Edge 10 presents stop (oe=0). Edge count is held in a 4-bit counter.
    - Then go to ACK.
  - ACK: on the 11th falling edge, sample the synchronized data. 0 means ack, so go to WAIT_IDLE; 1 means pulse tx_error and go to IDLE.
  - WAIT_IDLE: wait until synchronized clock and data are both 1, then pulse tx_done and go to IDLE.
- Timeout counter (19 bits):
  - Cleared on entry to SEND and on every falling edge.
  - In SEND, before the first edge, expiry at START_TIMEOUT ends the transfer.
  - After the first edge, and in ACK and WAIT_IDLE, expiry at BIT_TIMEOUT ends the transfer.
  - Any expiry: tx_error pulse, both oe outputs 0, go to IDLE.
- tx_busy = (state != IDLE).

Boundary cases:
- tx_valid while busy is ignored; there is no queue.
- tx_valid in the same cycle that tx_done or tx_error pulses is ignored, because tx_ready is still 0. It is accepted on the next cycle.
- A device frame already in progress when a request starts is aborted by the inhibit, as the protocol intends. tx_busy tells the receiver to drop that frame.
- tx_done and tx_error are never both asserted in the same cycle.

## Timing
- Reset: state=IDLE; ps2_clk_oe=0, ps2_dat_oe=0, tx_ready=1, tx_busy=0, tx_done=0, tx_error=0; shift register and counters cleared.
- Reset mid-transfer: both lines are released on the cycle after rst is sampled high, with no done or error pulse.
- tx_valid sampled at cycle T gives ps2_clk_oe=1 and tx_busy=1 from T+1.
- ps2_clk_oe is high for exactly INHIBIT_CYCLES+REQ_CYCLES cycles.
- ps2_dat_oe rises INHIBIT_CYCLES cycles after ps2_clk_oe rises.
- A pin falling edge updates ps2_dat_oe 3 cycles later (2 sync + 1 register). This is well inside the ≥5 µs clock-low half period.
- Ack sampling: the ack is read from data synchronized through the same path, at the cycle the 11th edge is detected.

## Structure
- Shared package/header ps2_defs: the state encoding (IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE) and the default timing constants. The existing receiver reuses the same constants.
- Sub-module ps2_sync_edge: 2-FF synchronizer plus falling-edge detector. The receiver reuses it.

## Test plan
- Byte 0xED; device model clocks at a 40 µs period and acks → bits 1,0,1,1,0,1,1,1 seen by the device, then parity 1 and stop 1; exactly one tx_done pulse; tx_busy falls in the same cycle as tx_done.
- Byte 0x00 → parity bit 1; byte 0xFF → parity bit 1; byte 0x01 → parity bit 0.
- Device never clocks → tx_error at START_TIMEOUT+INHIBIT_CYCLES+REQ_CYCLES+1 cycles after accept; both oe outputs 0.
- Device leaves data high on the 11th edge → one tx_error pulse and no tx_done.
- rst asserted during SEND (edge 5) → both oe outputs 0 and tx_ready=1 on the next cycle; no pulses.
- tx_valid held high through a whole transfer → exactly one byte sent, then a second transfer starts 1 cycle after tx_done.

Source files
------------

// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, default timing at 25 MHz,
// and the frame parity helper.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE
  } state_t;

  localparam int unsigned INHIBIT_CYCLES_DEF = 2500;
  localparam int unsigned REQ_CYCLES_DEF     = 25;
  localparam int unsigned START_TIMEOUT_DEF  = 375000;
  localparam int unsigned BIT_TIMEOUT_DEF    = 50000;
  localparam int unsigned TMR_W              = 19;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between the core and the PS/2 transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_busy, tx_done, tx_error
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_busy, tx_done, tx_error
  );
endinterface

// File: rtl/ps2_sync_edge.sv
// 2-FF synchronizer for a raw PS/2 pin plus a falling-edge strobe on the
// synchronized level. Flops reset high to match the idle bus.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic fall
);
  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic last_q, last_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    last_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      last_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      last_q <= last_d;
    end
  end

  assign dout = sync_q;
  assign fall = last_q & ~sync_q;
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, 10-bit frame
// clocked out by the device, ack check and wait for bus idle.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int unsigned REQ_CYCLES     = REQ_CYCLES_DEF,
  parameter int unsigned START_TIMEOUT  = START_TIMEOUT_DEF,
  parameter int unsigned BIT_TIMEOUT    = BIT_TIMEOUT_DEF
) (
  input  logic         clk25,
  input  logic         rst,
  ps2_host_tx_if.slave tx,
  input  logic         ps2_clk_in,
  input  logic         ps2_dat_in,
  output logic         ps2_clk_oe,
  output logic         ps2_dat_oe
);
  localparam logic [TMR_W-1:0] INH_LAST  = TMR_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] REQ_LAST  = TMR_W'(REQ_CYCLES - 1);
  localparam logic [TMR_W-1:0] START_LIM = TMR_W'(START_TIMEOUT);
  localparam logic [TMR_W-1:0] BIT_LIM   = TMR_W'(BIT_TIMEOUT);

  state_t           state_q, state_d;
  logic [9:0]       shift_q, shift_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic clk_s, clk_fall, dat_s, dat_fall_unused;
  logic ready, tmr_expired, abort;

  ps2_sync_edge u_clk_sync (.clk(clk25), .rst(rst), .din(ps2_clk_in), .dout(clk_s), .fall(clk_fall));
  ps2_sync_edge u_dat_sync (.clk(clk25), .rst(rst), .din(ps2_dat_in), .dout(dat_s), .fall(dat_fall_unused));

  // Ready stays low during the done/error pulse so a request in that cycle is not taken.
  assign ready       = (state_q == ST_IDLE) && !done_q && !err_q;
  assign tmr_expired = (state_q == ST_SEND && cnt_q == '0) ? (tmr_q == START_LIM) : (tmr_q == BIT_LIM);

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q + TMR_W'(1);
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    abort    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tmr_d    = '0;
        cnt_d    = '0;
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (tx.tx_valid && ready) begin
          shift_d  = {1'b1, odd_parity(tx.tx_data), tx.tx_data};
          clk_oe_d = 1'b1;
          state_d  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (tmr_q == INH_LAST) begin
          tmr_d    = '0;
          dat_oe_d = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (tmr_q == REQ_LAST) begin
          tmr_d    = '0;
          clk_oe_d = 1'b0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (clk_fall) begin
          tmr_d    = '0;
          dat_oe_d = ~shift_q[0];
          shift_d  = {1'b0, shift_q[9:1]};
          cnt_d    = cnt_q + 4'd1;
          if (cnt_q == 4'd9) state_d = ST_ACK;
        end else begin
          abort = tmr_expired;
        end
      end
      ST_ACK: begin
        if (clk_fall) begin
          tmr_d = '0;
          if (!dat_s) begin
            state_d = ST_WAIT_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          abort = tmr_expired;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_s && dat_s) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          abort = tmr_expired;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      err_d    = 1'b1;
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      state_d  = ST_IDLE;
    end
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      tmr_q    <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign tx.tx_ready  = ready;
  assign tx.tx_busy   = (state_q != ST_IDLE);
  assign tx.tx_done   = done_q;
  assign tx.tx_error  = err_q;
  assign ps2_clk_oe   = clk_oe_q;
  assign ps2_dat_oe   = dat_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboarded bench for ps2_host_tx with a behavioural PS/2 keyboard model
// on the open-drain clock/data pair.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int unsigned INH  = 40;
  localparam int unsigned REQC = 6;
  localparam int unsigned STO  = 300;
  localparam int unsigned BTO  = 200;
  localparam int unsigned HALF = 12;
  localparam int M_ACK    = 0;
  localparam int M_NOACK  = 1;
  localparam int M_SILENT = 2;

  logic clk25 = 1'b0;
  logic rst   = 1'b1;
  logic ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  int   dev_mode   = M_ACK;
  int   dev_edges  = 0;
  bit   dev_active = 1'b0;
  logic [10:0] dev_frame = '0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    bit          is_done;
    bit          chk_frame;
    logic [10:0] frame;
  } exp_t;
  exp_t sbq[$];

  ps2_host_tx_if bus();

  always #20 clk25 = ~clk25;

  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .REQ_CYCLES    (REQC),
    .START_TIMEOUT (STO),
    .BIT_TIMEOUT   (BTO)
  ) dut (
    .clk25     (clk25),
    .rst       (rst),
    .tx        (bus),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame as the device sees it on the wire: start, D0..D7, odd parity, stop.
  function automatic logic [10:0] ref_frame(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = ($countones(d) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Keyboard model: answers a request-to-send with 11 clock pulses, samples
  // data on each rising clock, and acks (or not) on the 11th pulse.
  initial begin
    logic [10:0] f;
    forever begin
      @(negedge clk25);
      if (dev_mode != M_SILENT && ps2_clk_in && !ps2_dat_in) begin
        dev_active = 1'b1;
        dev_edges  = 0;
        f          = '0;
        repeat (HALF) @(negedge clk25);
        f[0] = ps2_dat_in;
        for (int k = 1; k <= 11; k++) begin
          if (k == 11 && dev_mode == M_ACK) dev_dat = 1'b0;
          dev_clk   = 1'b0;
          dev_edges = k;
          repeat (HALF) @(negedge clk25);
          dev_clk = 1'b1;
          if (k <= 10) f[k] = ps2_dat_in;
          if (k == 10) dev_frame = f;
          repeat (HALF) @(negedge clk25);
        end
        dev_dat    = 1'b1;
        dev_active = 1'b0;
      end
    end
  end

  // Monitor: every done/error pulse consumes one expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk25);
      if (bus.tx_done || bus.tx_error) begin
        check("done_err_exclusive", 32'(bus.tx_done & bus.tx_error), 0);
        check("busy_low_at_pulse", 32'(bus.tx_busy), 0);
        check("ready_low_at_pulse", 32'(bus.tx_ready), 0);
        if (sbq.size() == 0) begin
          check("unexpected_pulse", bus.tx_done ? 32'd1 : 32'd2, 0);
        end else begin
          e = sbq.pop_front();
          check("pulse_is_done", 32'(bus.tx_done), 32'(e.is_done));
          if (e.chk_frame) check("frame_bits", 32'(dev_frame), 32'(e.frame));
        end
      end
    end
  end

  task automatic push_exp(input logic [7:0] d, input int mode);
    exp_t e;
    e.is_done   = (mode == M_ACK);
    e.chk_frame = (mode != M_SILENT);
    e.frame     = (mode != M_SILENT) ? ref_frame(d) : '0;
    sbq.push_back(e);
  endtask

  // Returns at accept edge + 1 time unit; the next negedge is the first cycle of the transfer.
  task automatic start_tx(input logic [7:0] d, input int mode, input bit hold,
                          input bit expect_it, output bit ok);
    int n = 0;
    @(negedge clk25);
    dev_mode     = mode;
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && n < 2000) begin
      @(negedge clk25);
      n++;
    end
    ok = bus.tx_ready;
    check("accept_ready", 32'(bus.tx_ready), 1);
    if (!ok) begin
      bus.tx_valid = 1'b0;
      return;
    end
    if (expect_it) push_exp(d, mode);
    @(posedge clk25);
    #1;
    if (!hold) bus.tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk25);
      n++;
    end while ((bus.tx_busy || dev_active || sbq.size() != 0) && n < 5000);
    repeat (2) @(negedge clk25);
    check(name, 32'(bus.tx_busy | dev_active), 0);
  endtask

  initial begin
    #8000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    int          j, cnt, first_dat, n, m;
    logic [7:0]  b;
    logic [7:0]  list [3];

    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk25);
    check("rst_ready", 32'(bus.tx_ready), 1);
    check("rst_busy", 32'(bus.tx_busy), 0);
    check("rst_done", 32'(bus.tx_done), 0);
    check("rst_error", 32'(bus.tx_error), 0);
    check("rst_clk_oe", 32'(ps2_clk_oe), 0);
    check("rst_dat_oe", 32'(ps2_dat_oe), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk25);

    // 0xED with inhibit / request timing
    start_tx(8'hED, M_ACK, 1'b0, 1'b1, ok);
    if (ok) begin
      cnt = 0; first_dat = -1; j = 0;
      @(negedge clk25);
      check("busy_after_accept", 32'(bus.tx_busy), 1);
      check("ready_after_accept", 32'(bus.tx_ready), 0);
      while (ps2_clk_oe && j < 10000) begin
        if (ps2_dat_oe && first_dat < 0) first_dat = j;
        cnt++; j++;
        @(negedge clk25);
      end
      check("clk_oe_high_cycles", 32'(cnt), INH + REQC);
      check("dat_oe_rise_offset", 32'(first_dat), INH);
      check("start_bit_at_release", 32'(ps2_dat_oe), 1);
    end
    wait_idle("idle_after_ed");

    // parity corner bytes
    list[0] = 8'h00; list[1] = 8'hFF; list[2] = 8'h01;
    for (int i = 0; i < 3; i++) begin
      start_tx(list[i], M_ACK, 1'b0, 1'b1, ok);
      wait_idle("idle_after_parity_byte");
    end

    // random bytes, occasionally without ack
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      m = ($urandom_range(0, 3) == 0) ? M_NOACK : M_ACK;
      start_tx(b, m, 1'b0, 1'b1, ok);
      wait_idle("idle_after_random");
    end

    // explicit no-ack
    start_tx(8'h5A, M_NOACK, 1'b0, 1'b1, ok);
    wait_idle("idle_after_noack");

    // device never clocks: start timeout
    start_tx(8'hF4, M_SILENT, 1'b0, 1'b1, ok);
    if (ok) begin
      j = 0;
      @(negedge clk25);
      while (!bus.tx_error && j < int'(STO + INH + REQC + 100)) begin
        @(negedge clk25);
        j++;
      end
      check("start_timeout_latency", 32'(j), STO + INH + REQC + 1);
      check("timeout_clk_oe", 32'(ps2_clk_oe), 0);
      check("timeout_dat_oe", 32'(ps2_dat_oe), 0);
    end
    wait_idle("idle_after_timeout");

    // reset in the middle of the frame, after device edge 5
    start_tx(8'hA5, M_ACK, 1'b0, 1'b0, ok);
    n = 0;
    while (dev_edges != 5 && n < 5000) begin
      @(negedge clk25);
      n++;
    end
    check("reached_edge5", 32'(dev_edges), 5);
    repeat (4) @(negedge clk25);
    check("busy_before_reset", 32'(bus.tx_busy), 1);
    rst = 1'b1;
    @(negedge clk25);
    check("midrst_clk_oe", 32'(ps2_clk_oe), 0);
    check("midrst_dat_oe", 32'(ps2_dat_oe), 0);
    check("midrst_ready", 32'(bus.tx_ready), 1);
    check("midrst_busy", 32'(bus.tx_busy), 0);
    rst = 1'b0;
    wait_idle("idle_after_midrst");

    // tx_valid held through a whole transfer
    start_tx(8'h3C, M_ACK, 1'b1, 1'b1, ok);
    if (ok) begin
      bus.tx_data = 8'hC3;
      j = 0;
      @(negedge clk25);
      while (!bus.tx_done && j < 5000) begin
        check("held_single_transfer", 32'(bus.tx_busy), 1);
        @(negedge clk25);
        j++;
      end
      check("held_done_seen", 32'(bus.tx_done), 1);
      @(negedge clk25);
      check("held_ready_after_done", 32'(bus.tx_ready), 1);
      check("held_busy_after_done", 32'(bus.tx_busy), 0);
      push_exp(8'hC3, M_ACK);
      @(posedge clk25);
      #1;
      bus.tx_valid = 1'b0;
      @(negedge clk25);
      check("held_second_started", 32'(bus.tx_busy), 1);
      check("held_second_clk_oe", 32'(ps2_clk_oe), 1);
    end
    bus.tx_valid = 1'b0;
    wait_idle("idle_after_held");

    check("scoreboard_drained", 32'(sbq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
